// File: rtl/oct5_key_entry_if.sv
// Keypad-to-register bundle for oct5_key_entry: key strobes in, digit buses and strobes out.
// The ovf signal exists only when OCT5_ENTRY_OVF_EN is defined.
interface oct5_key_entry_if;
   logic       key_valid;
   logic [2:0] key_digit;
   logic       key_del;
   logic       key_clr;
   logic       key_enter;
   logic [2:0] data_o_0;
   logic [2:0] data_o_1;
   logic [2:0] data_o_2;
   logic [2:0] data_o_3;
   logic [2:0] data_o_4;
   logic       write_en;
   logic       read_en;
   logic [2:0] digit_cnt;
   logic       busy;
`ifdef OCT5_ENTRY_OVF_EN
   logic       ovf;
`endif

   // Keypad / test side.
   modport master (
      output key_valid, key_digit, key_del, key_clr, key_enter,
`ifdef OCT5_ENTRY_OVF_EN
      input  ovf,
`endif
      input  data_o_0, data_o_1, data_o_2, data_o_3, data_o_4,
      input  write_en, read_en, digit_cnt, busy
   );

   // Entry block side.
   modport slave (
      input  key_valid, key_digit, key_del, key_clr, key_enter,
`ifdef OCT5_ENTRY_OVF_EN
      output ovf,
`endif
      output data_o_0, data_o_1, data_o_2, data_o_3, data_o_4,
      output write_en, read_en, digit_cnt, busy
   );
endinterface

// File: rtl/oct5_key_entry.sv
// Octal keypad entry front-end for the 5-digit octal register: shift buffer, delete/clear, commit.
// Define OCT5_ENTRY_OVF_EN to add the sticky ovf flag for digits keyed while the buffer is full.
module oct5_key_entry #(
   parameter int AUTO_COMMIT  = 0,
   parameter int WR_PULSE_LEN = 1   // 1..7
) (
   input logic             clk,
   input logic             rst,
   oct5_key_entry_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_FULL, S_COMMIT, S_READ, S_DONE
   } state_t;

   localparam logic [2:0] WR_LEN = 3'(WR_PULSE_LEN);

   state_t     state;
   logic [2:0] dig [5];
   logic [2:0] cnt;
   logic [2:0] wr_cnt;
   logic       write_q;
   logic       read_q;
   logic       busy_q;
   logic       ovf_q;

   // Only the highest-priority key in a cycle acts.
   logic do_clr, do_del, do_ent, do_dig;
   always_comb begin
      do_clr = bus.key_clr;
      do_del = !bus.key_clr && bus.key_del;
      do_ent = !bus.key_clr && !bus.key_del && bus.key_enter;
      do_dig = !bus.key_clr && !bus.key_del && !bus.key_enter && bus.key_valid;
   end

   // NOTE: all state here is sequential, so every assignment in this block is non-blocking;
   // the digit array is five flops, not a RAM, so it is cleared on reset like the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         for (int i = 0; i < 5; i++) dig[i] <= '0;
         cnt     <= '0;
         wr_cnt  <= '0;
         write_q <= 1'b0;
         read_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            S_COMMIT: begin
               if (wr_cnt == WR_LEN) begin
                  write_q <= 1'b0;
                  read_q  <= 1'b1;
                  state   <= S_READ;
               end else begin
                  wr_cnt <= wr_cnt + 3'd1;
               end
            end
            S_READ: begin
               read_q <= 1'b0;
               busy_q <= 1'b0;
               cnt    <= '0;
               state  <= S_DONE;
            end
            default: begin
               if (do_clr || (do_del && state == S_DONE)) begin
                  for (int i = 0; i < 5; i++) dig[i] <= '0;
                  cnt   <= '0;
                  ovf_q <= 1'b0;
                  state <= S_IDLE;
               end else if (do_del) begin
                  if (cnt != 3'd0) begin
                     for (int i = 0; i < 4; i++) dig[i] <= dig[i+1];
                     dig[4] <= '0;
                     cnt    <= cnt - 3'd1;
                     ovf_q  <= 1'b0;
                     state  <= (cnt == 3'd1) ? S_IDLE : S_ENTRY;
                  end
               end else if (do_ent || (AUTO_COMMIT != 0 && state == S_FULL)) begin
                  // IDLE is the only non-busy state with nothing to send.
                  if (state != S_IDLE) begin
                     wr_cnt  <= 3'd1;
                     write_q <= 1'b1;
                     busy_q  <= 1'b1;
                     ovf_q   <= 1'b0;
                     state   <= S_COMMIT;
                  end
               end else if (do_dig) begin
                  case (state)
                     S_IDLE, S_ENTRY: begin
                        for (int i = 4; i > 0; i--) dig[i] <= dig[i-1];
                        dig[0] <= bus.key_digit;
                        cnt    <= cnt + 3'd1;
                        state  <= (cnt == 3'd4) ? S_FULL : S_ENTRY;
                     end
                     S_DONE: begin
                        for (int i = 1; i < 5; i++) dig[i] <= '0;
                        dig[0] <= bus.key_digit;
                        cnt    <= 3'd1;
                        state  <= S_ENTRY;
                     end
                     default: begin
`ifdef OCT5_ENTRY_OVF_EN
                        ovf_q <= 1'b1;
`endif
                     end
                  endcase
               end
            end
         endcase
      end
   end

   assign bus.data_o_0  = dig[0];
   assign bus.data_o_1  = dig[1];
   assign bus.data_o_2  = dig[2];
   assign bus.data_o_3  = dig[3];
   assign bus.data_o_4  = dig[4];
   assign bus.write_en  = write_q;
   assign bus.read_en   = read_q;
   assign bus.digit_cnt = cnt;
   assign bus.busy      = busy_q;
`ifdef OCT5_ENTRY_OVF_EN
   assign bus.ovf       = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif

endmodule
